sincos_sched: RTL and testbench
===============================

// Module: sincos_sched
// PURPOSE
//  Shares one pipelined sincos (CORDIC) core between N_REQ requesters.
//  - Round-robin arbitration; at most one angle issued per cycle.
//  - Each issue is tagged and tracked down the core's fixed pipeline.
//  - Each sin/cos result is returned to the requester that issued it.
//  - Core clock-enable is gated off when the pipeline holds no work.
//  Sits between the per-channel angle generators and the single sincos instance.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  WIDTH    27  angle / sin / cos width, two's complement, matches core
//  LATENCY  27  sincos core latency, in enabled cycles, angle in -> sin/cos out
// PORTS
//  clk        in   1             single clock, rising edge
//  reset_n    in   1             synchronous active-low reset
//  req_valid  in   N_REQ         requester i presents an angle
//  req_angle  in   N_REQ*WIDTH   angle of requester i, slice [i*WIDTH +: WIDTH]
//  req_ready  out  N_REQ         one-hot grant; transfer = req_valid[i] & req_ready[i]
//  rsp_valid  out  N_REQ         one-hot; result for requester i valid this cycle
//  rsp_sin    out  WIDTH         shared result bus, sin
//  rsp_cos    out  WIDTH         shared result bus, cos
//  cs_en      out  1             to core en
//  cs_angle   out  WIDTH         to core angle (registered)
//  cs_sin     in   WIDTH         from core sin
//  cs_cos     in   WIDTH         from core cos
//  busy       out  1             any request in flight
// BEHAVIOUR
//  - Reset (reset_n low at posedge):
//    - Outputs: rsp_valid=0, rsp_sin=0, rsp_cos=0, cs_angle=0, cs_en=0, busy=0.
//    - RR pointer = 0; tag pipe cleared.
//    - Results in flight at reset are discarded and never returned.
//  - Arbitration:
//    - req_ready is combinational from req_valid and the RR pointer.
//    - Search order starts at the pointer and wraps modulo N_REQ.
//    - The first requester asserting valid in that order is granted.
//    - After a grant to i, the pointer becomes (i+1) mod N_REQ.
//    - With no request, the pointer holds.
//    - Requesters must not make req_valid depend on req_ready.
//    - req_ready=0 on every line during reset.
//  - Issue:
//    - On a transfer, cs_angle <= req_angle[i] and a tag {v=1, id=i} enters the tag pipe.
//    - With no transfer, a tag {v=0} enters the tag pipe instead.
//  - Tag pipe:
//    - LATENCY+1 stages: 1 for the cs_angle register plus LATENCY core stages.
//    - Advances only on cycles where cs_en=1, so it stays aligned with the core.
//  - cs_en:
//    - Registered.
//    - High in the cycle after a transfer.
//    - Also high while any stage of the tag pipe has v=1.
//    - The pipe never stalls while holding valid data, so latency is fixed.
//  - Response:
//    - The tag pipe output stage has v=1 exactly when core sin/cos for that tag are present.
//    - Registered on the next edge: rsp_valid <= onehot(id), rsp_sin/rsp_cos <= cs_sin/cs_cos.
//    - rsp_sin/rsp_cos hold their last value when rsp_valid=0.
//  - Latency:
//    - Transfer at edge k gives rsp_valid high for exactly one cycle.
//    - That cycle starts at edge k+LATENCY+2.
//  - Throughput:
//    - 1 result per cycle across all requesters.
//    - No response backpressure; requesters must accept rsp.
//  - busy = OR of the tag v bits, the cs_angle-stage v bit and rsp_valid.
//  - Simultaneous issue and retire in one cycle is legal and loses nothing.
//  - Width: angles and results pass through unmodified; no arithmetic in this block.
// STRUCTURE
//  - sincos_pkg:
//    - WIDTH and LATENCY constants.
//    - typedef id_t  = logic [$clog2(N_REQ)-1:0].
//    - typedef tag_t = struct packed {logic v; id_t id;}.
//  - Sub-module rr_arbiter #(N_REQ):
//    - Inputs req and advance; outputs one-hot gnt and gnt_id.
//    - Combinational grant plus registered pointer.
//  - Top level holds the issue register, tag shift register, cs_en logic and response register.
// TESTING
//  - Single request:
//    - Stimulus: after reset, req_valid=4'b0100, req_angle[2]=27'd251 for one transfer.
//    - Response: rsp_valid=4'b0100 exactly LATENCY+2 cycles later.
//    - rsp_sin/rsp_cos equal the direct sincos model for angle 251.
//  - Saturation:
//    - Stimulus: all four requesters valid for 12 cycles.
//    - Response: grants 0,1,2,3,0,1,... one per cycle.
//    - 12 responses back-to-back, ids in grant order.
//  - Fairness:
//    - Stimulus: requesters 1 and 3 valid continuously, pointer starting at 0.
//    - Response: grants alternate 1,3,1,3.
//    - Each id returns the angle it sent; use distinct angles per request.
//  - Gating:
//    - Stimulus: one request, then idle.
//    - Response: cs_en high from the cycle after the transfer until the tag retires, then 0.
//    - busy drops in the cycle after rsp_valid.
//  - Reset mid-flight:
//    - Stimulus: 5 transfers, then reset_n=0 for 2 cycles, 10 cycles after the first transfer.
//    - Response: no rsp_valid afterwards; cs_en=0; pointer=0.
//    - A new request then completes with normal latency.
//  - Sparse plus burst mix:
//    - Stimulus: randomised req_valid streams against a scoreboard.
//    - Response: every accepted angle returns exactly once, to the correct id, in issue order.

Source files
------------

// File: rtl/sincos_pkg.sv
// Shared constants and tag types for the sincos request scheduler.
package sincos_pkg;

  localparam int SC_N_REQ   = 4;
  localparam int SC_WIDTH   = 27;
  localparam int SC_LATENCY = 27;
  localparam int ID_W       = (SC_N_REQ > 1) ? $clog2(SC_N_REQ) : 1;

  typedef logic [ID_W-1:0] id_t;

  // One tag per pipeline slot: v marks real work, id names the requester it belongs to.
  typedef struct packed {
    logic v;
    id_t  id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered pointer.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     advance,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id
);

  localparam int GW = $clog2(N_REQ);

  logic [GW-1:0] ptr;
  int            idx;
  logic          found;

  // Walk the requesters starting at the pointer, wrapping around, and grant the first one asserting req.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = GW'(idx);
      end
    end
  end

  // After a grant the pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + GW'(1);
    end
  end

endmodule

// File: rtl/sincos_sched.sv
// Shares one fixed-latency sincos core between several requesters.
// Issues at most one angle per cycle, tracks each issue with a tag that moves
// in lock-step with the core, and steers each result back to its requester.
module sincos_sched
  import sincos_pkg::*;
#(
  parameter int N_REQ   = SC_N_REQ,
  parameter int WIDTH   = SC_WIDTH,
  parameter int LATENCY = SC_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_angle,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_sin,
  output logic [WIDTH-1:0]       rsp_cos,
  output logic                   cs_en,
  output logic [WIDTH-1:0]       cs_angle,
  input  logic [WIDTH-1:0]       cs_sin,
  input  logic [WIDTH-1:0]       cs_cos,
  output logic                   busy
);

  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [GW-1:0]    gnt_id;
  logic             transfer;
  logic [WIDTH-1:0] sel_angle;

  tag_t             issue_tag;
  tag_t             tag_pipe [LATENCY+1];
  tag_t             out_tag;
  logic [LATENCY:0] pipe_v_next;
  logic             en_next;
  logic             any_tag_v;

  // Nothing is granted while reset is held, so no requester sees a transfer then.
  assign arb_req   = reset_n ? req_valid : '0;
  assign req_ready = gnt;
  assign transfer  = |gnt;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (arb_req),
    .advance (transfer),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // Pick the winning requester's angle off the flat input bus.
  always_comb begin
    sel_angle = req_angle[int'(gnt_id)*WIDTH +: WIDTH];
  end

  // Issue stage: the angle register feeding the core plus the tag travelling with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_angle  <= '0;
      issue_tag <= '0;
    end else begin
      issue_tag.v  <= transfer;
      issue_tag.id <= id_t'(gnt_id);
      if (transfer) begin
        cs_angle <= sel_angle;
      end
    end
  end

  // Tag shift register, advanced only with the core so each tag meets its own result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_pipe[s] <= '0;
      end
    end else if (cs_en) begin
      tag_pipe[0] <= issue_tag;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // Look ahead at where the valid bits will be after this edge to decide if the core must run next cycle.
  always_comb begin
    pipe_v_next = '0;
    any_tag_v   = 1'b0;
    for (int s = 0; s <= LATENCY; s++) begin
      pipe_v_next[s] = tag_pipe[s].v;
      any_tag_v      = any_tag_v | tag_pipe[s].v;
    end
    if (cs_en) begin
      pipe_v_next[0] = issue_tag.v;
      for (int s = 1; s <= LATENCY; s++) begin
        pipe_v_next[s] = tag_pipe[s-1].v;
      end
    end
    en_next = transfer | (|pipe_v_next);
  end

  // Core enable is registered; it stays high until the last valid tag has been shifted out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_en <= 1'b0;
    end else begin
      cs_en <= en_next;
    end
  end

  assign out_tag = tag_pipe[LATENCY];

  // Capture the core result when the output tag is valid; the data bus holds between results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_sin   <= '0;
      rsp_cos   <= '0;
    end else begin
      rsp_valid <= '0;
      if (out_tag.v) begin
        rsp_valid[out_tag.id] <= 1'b1;
        rsp_sin               <= cs_sin;
        rsp_cos               <= cs_cos;
      end
    end
  end

  assign busy = any_tag_v | issue_tag.v | (|rsp_valid);

endmodule

// File: tb/tb_sincos_sched.sv
// Self-checking bench for sincos_sched: a behavioural sincos core stand-in,
// a round-robin grant model and a response scoreboard keyed by due cycle.
module tb_sincos_sched;
  import sincos_pkg::*;

  localparam int N = 4;
  localparam int W = 27;
  localparam int L = 27;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_angle = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] rsp_valid;
  logic [W-1:0] rsp_sin;
  logic [W-1:0] rsp_cos;
  logic         cs_en;
  logic [W-1:0] cs_angle;
  logic [W-1:0] cs_sin;
  logic [W-1:0] cs_cos;
  logic         busy;

  always #5 clk = ~clk;

  sincos_sched #(
    .N_REQ   (N),
    .WIDTH   (W),
    .LATENCY (L)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sin   (rsp_sin),
    .rsp_cos   (rsp_cos),
    .cs_en     (cs_en),
    .cs_angle  (cs_angle),
    .cs_sin    (cs_sin),
    .cs_cos    (cs_cos),
    .busy      (busy)
  );

  // Angle is a two's complement fraction of a half turn; results scaled by 2^25.
  function automatic logic [W-1:0] sin_of(input logic [W-1:0] a);
    real ang;
    ang = $itor($signed(a)) * 3.14159265358979 / 67108864.0;
    return W'($rtoi($sin(ang) * 33554432.0));
  endfunction

  function automatic logic [W-1:0] cos_of(input logic [W-1:0] a);
    real ang;
    ang = $itor($signed(a)) * 3.14159265358979 / 67108864.0;
    return W'($rtoi($cos(ang) * 33554432.0));
  endfunction

  // Core stand-in: samples its angle on an enabled edge, result appears L enabled edges later.
  logic [W-1:0] core_pipe [0:L] = '{default: '0};
  always @(posedge clk) begin
    if (cs_en) begin
      core_pipe[0] <= cs_angle;
      for (int s = 1; s <= L; s++) core_pipe[s] <= core_pipe[s-1];
    end
  end
  assign cs_sin = sin_of(core_pipe[L]);
  assign cs_cos = cos_of(core_pipe[L]);

  typedef struct {
    int           id;
    logic [W-1:0] angle;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           cycle = 0;
  int           model_ptr = 0;
  logic [W-1:0] last_sin = '0;
  logic [W-1:0] last_cos = '0;
  int           checks = 0;
  int           errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", name, obs, expv, cycle);
    end
  endtask

  function automatic logic [N*W-1:0] rand_angles();
    logic [N*W-1:0] a;
    for (int i = 0; i < N; i++) a[i*W +: W] = W'($urandom);
    return a;
  endfunction

  // One clock cycle: drive inputs, check grant, advance, then check everything the DUT returned.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] a);
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rsp;
    int           g;
    bit           popped;
    exp_t         e;
    req_valid = v;
    req_angle = a;
    #1;
    exp_gnt = '0;
    g = -1;
    if (reset_n) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(model_ptr + k) % N]) g = (model_ptr + k) % N;
      end
    end
    if (g >= 0) exp_gnt[g] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_gnt));
    @(posedge clk);
    cycle++;
    if (!reset_n) begin
      exp_q.delete();
      model_ptr = 0;
      last_sin  = '0;
      last_cos  = '0;
    end else if (g >= 0) begin
      e.id    = g;
      e.angle = a[g*W +: W];
      e.due   = cycle + L + 2;
      exp_q.push_back(e);
      model_ptr = (g + 1) % N;
    end
    @(negedge clk);
    exp_rsp = '0;
    popped  = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
      exp_rsp[exp_q[0].id] = 1'b1;
      last_sin = sin_of(exp_q[0].angle);
      last_cos = cos_of(exp_q[0].angle);
      popped   = 1'b1;
    end
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    checkOutput("rsp_sin", 32'(rsp_sin), 32'(last_sin));
    checkOutput("rsp_cos", 32'(rsp_cos), 32'(last_cos));
    checkOutput("busy", 32'(busy), 32'(exp_q.size() > 0));
    checkOutput("cs_en", 32'(cs_en), 32'(exp_q.size() > 0 && exp_q[$].due > cycle));
    if (popped) void'(exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, rand_angles());
  endtask

  task automatic doReset(input int n);
    reset_n = 1'b0;
    idle(n);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [N*W-1:0] ang;
    logic [N-1:0]   v;

    $display("[TB] reset");
    doReset(3);
    checkOutput("cs_angle_reset", 32'(cs_angle), 32'(0));

    $display("[TB] single request");
    ang = rand_angles();
    ang[2*W +: W] = 27'd251;
    applyStimulus(4'b0100, ang);
    checkOutput("cs_angle_issue", 32'(cs_angle), 32'(251));
    idle(L + 5);

    $display("[TB] saturation");
    doReset(2);
    for (int i = 0; i < 12; i++) applyStimulus('1, rand_angles());
    idle(L + 5);

    $display("[TB] fairness");
    doReset(2);
    for (int i = 0; i < 8; i++) applyStimulus(4'b1010, rand_angles());
    idle(L + 5);

    $display("[TB] reset mid-flight");
    doReset(2);
    for (int i = 0; i < 5; i++) applyStimulus('1, rand_angles());
    idle(4);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(L + 5);
    applyStimulus('1, rand_angles());
    idle(L + 5);

    $display("[TB] random mix");
    for (int seg = 0; seg < 10; seg++) begin
      for (int i = 0; i < 50; i++) begin
        if (seg % 2 == 0) v = N'($urandom & $urandom & $urandom);
        else              v = N'($urandom | $urandom);
        applyStimulus(v, rand_angles());
      end
    end
    idle(L + 5);
    checkOutput("drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
